// File: rtl/tdm_pkg.sv
// Shared widths, state encoding and helpers for the 8:1 TDM receive path.
package tdm_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } state_t;

  // Even-parity check: 1 when the word plus its parity bit has odd weight.
  function automatic logic parity_fail(input logic [DATA_W-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// 3-to-8 one-hot slot decoder; receive-side inverse of the transmit 8:1 mux.
module tdm_slot_decoder
  import tdm_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  output logic [DATA_W-1:0] we_c
);

  // One write enable per slot, all low when disabled.
  always_comb begin
    we_c      = '0;
    if (en) begin
      we_c[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// 8:1 TDM serial-to-parallel receiver: slot counter, assembly register,
// registered word/valid/error outputs. Optional trailing even-parity beat
// is enabled by defining TDM_PARITY_EN.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              frame_start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic [SEL_W-1:0]  slot
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    slot_d;
  logic [DATA_W-1:0]   asm_q, asm_d, asm_wr;
  logic [DATA_W-1:0]   out_data_d;
  logic                out_valid_d, frame_err_d, parity_err_d;
  logic                wr_en;
  logic [SEL_W-1:0]    wr_slot;
  logic [DATA_W-1:0]   we;

  // A frame_start beat always lands in slot 0; otherwise only COLLECT writes.
  assign wr_en   = in_valid & (frame_start | (state_q == ST_COLLECT));
  assign wr_slot = frame_start ? '0 : slot;

  tdm_slot_decoder u_dec (
    .sel  (wr_slot),
    .en   (wr_en),
    .we_c (we)
  );

  // Assembly register with the current beat merged in.
  assign asm_wr = (asm_q & ~we) | (we & {DATA_W{in_bit}});

  // Next-state, slot counter and output pulse logic.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot;
    asm_d        = asm_q;
    out_data_d   = out_data;
    out_valid_d  = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && frame_start) begin
          asm_d   = asm_wr;
          slot_d  = SEL_W'(1);
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (in_valid) begin
          asm_d = asm_wr;
          if (frame_start) begin
            // Restart mid-frame: partial word dropped, this beat is slot 0.
            frame_err_d = 1'b1;
            slot_d      = SEL_W'(1);
          end else if (slot == SEL_W'(DATA_W - 1)) begin
            slot_d = '0;
`ifdef TDM_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d     = ST_IDLE;
            out_data_d  = asm_wr;
            out_valid_d = 1'b1;
`endif
          end else begin
            slot_d = slot + SEL_W'(1);
          end
        end
      end

`ifdef TDM_PARITY_EN
      ST_PARITY: begin
        if (in_valid) begin
          if (frame_start) begin
            frame_err_d = 1'b1;
            asm_d       = asm_wr;
            slot_d      = SEL_W'(1);
            state_d     = ST_COLLECT;
          end else begin
            out_data_d   = asm_q;
            out_valid_d  = 1'b1;
            parity_err_d = parity_fail(asm_q, in_bit);
            state_d      = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      slot       <= '0;
      asm_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot       <= slot_d;
      asm_q      <= asm_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
    end
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the team's 8:1 time-division link. The transmitter drives one bit per beat through an 8-to-1 mux under a 3-bit slot counter.
- This block recovers the 8 parallel channel bits from that serial stream. It uses a slot counter and a 3-to-8 slot decoder to steer each beat into its register bit.
- It then presents the assembled word with a one-cycle valid pulse. It sits directly after the serial link, ahead of the majority/voting logic that consumes parallel words.

Parameters:
- DATA_W, 8, number of slots per frame (channel bits per word); fixed at 8 for this revision.
- SEL_W, 3, slot counter width; must equal log2(DATA_W).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a serial beat is present on in_bit this cycle.
- in_bit  input  1  serial data bit; qualified by in_valid.
- frame_start  input  1  marks the slot-0 beat; qualified by in_valid.
- out_data  output  DATA_W  last completed word; slot i lands in out_data[i] (slot 0 = LSB).
- out_valid  output  1  one-cycle pulse: out_data updated this cycle.
- frame_err  output  1  one-cycle pulse: frame_start seen mid-frame.
- parity_err  output  1  one-cycle pulse coincident with out_valid when parity fails. Tied 0 without the optional feature.
- slot  output  SEL_W  index the next accepted beat will be written to.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - state=IDLE, slot=0, shift/assembly register=0.
  - out_data=0, out_valid=0, frame_err=0, parity_err=0.
  - Reset has priority over every other event, including mid-frame: the partial frame is discarded and no out_valid is issued.
- States: IDLE, COLLECT (PARITY added with optional feature).
- IDLE:
  - Beats with in_valid=1 and frame_start=0 are ignored; no error.
  - in_valid=1 and frame_start=1: write in_bit to assembly[0], set slot=1, go to COLLECT.
- COLLECT:
  - in_valid=0: hold everything; gaps of any length are allowed.
  - in_valid=1, frame_start=0: write in_bit to assembly[slot], slot=slot+1.
  - On the slot-7 beat, slot wraps to 0 and the state goes to IDLE.
  - The next cycle, out_data = full assembled word (including the slot-7 bit) and out_valid=1.
  - Latency: out_valid occurs exactly 1 cycle after the slot-7 beat.
  - in_valid=1, frame_start=1 (slot != 0): frame_err=1 next cycle. Discard the partial word (out_data unchanged), treat this beat as a new slot 0, set slot=1, stay in COLLECT.
- Back-to-back frames: frame_start on the beat immediately after slot 7 is legal. out_valid for the old frame and acceptance of the new slot 0 happen in the same cycle.
- out_data holds its value between frames. out_valid, frame_err and parity_err are single-cycle pulses and never stretch.
- Assembly register bits not yet written in the current frame are don't-care internally but never visible on out_data.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined: after the slot-7 beat, go to PARITY instead of IDLE.
  - The next in_valid beat is an even-parity bit.
  - One cycle after it, out_valid=1. parity_err=1 in the same cycle if (^assembled_word) ^ parity_bit = 1. The data is still delivered.
  - frame_start in PARITY: frame_err, restart as slot 0, no out_valid.
  - slot reads 0 while in PARITY.
- Undefined: no PARITY state; parity_err constant 0.

Decomposition:
- Shared package tdm_pkg: DATA_W, SEL_W, state encoding constants (ST_IDLE, ST_COLLECT, ST_PARITY).
- One sub-module: tdm_slot_decoder, a combinational 3-to-8 one-hot decoder (slot, enable) -> write-enable vector. It is the structural inverse of the transmit-side 8:1 mux.
- The top module holds the FSM, counter, assembly register and output registers.

Test Plan:
- Reset then frame 0xA5, sent LSB first on 8 consecutive beats with frame_start on the first → out_data=0xA5 and out_valid=1 exactly 1 cycle after the 8th beat; frame_err=0.
- Frame 0x3C with in_valid low for 2 cycles after slots 2 and 5 → out_data=0x3C; out_valid only after the slot-7 beat; slot holds across gaps.
- Frame 0xFF, 4 beats in, then frame_start with frame 0x12 → frame_err pulse 1 cycle later; out_data=0x12 after the 0x12 frame; 0xFF never appears.
- Frames 0x81 and 0x7E back-to-back with no idle beat → two out_valid pulses 8 cycles apart; values 0x81 then 0x7E.
- Reset asserted after slot 4 of 0x55 → all outputs 0 next cycle; no out_valid; next full frame 0x0F decodes correctly.
- TDM_PARITY_EN: 0xA5 with parity 0 → out_valid and parity_err=0. 0xA5 with parity 1 → out_valid and parity_err=1; out_data=0xA5.
